mcast_ingress_port: RTL and testbench
=====================================

MCAST_INGRESS_PORT -- requirements
Module: mcast_ingress_port

Interface
REQ-001 The module SHALL have parameters: FLIT_W, 64, flit width; DEPTH, 4, buffer entries (power of two, >=2); PORT_ID, 0, this input's port index (0-4).
REQ-002 The module SHALL have one clock, clk, and an asynchronous, active-low reset, rst_n; ports are listed below, clock and reset first.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable_mcast  input  1  1: head bits [4:0] are a destination mask; 0: head bits [2:0] are a unicast port index.
REQ-006 in_valid / in_ready  input / output  1 / 1  upstream flit handshake.
REQ-007 in_flit  input  FLIT_W  incoming flit.
REQ-008 req  output  5  per-output request mask toward the router crossbar.
REQ-009 head_flit  output  FLIT_W  buffered head flit, stable while req!=0.
REQ-010 grant  input  5  per-output grants from the crossbar arbiters.
REQ-011 fifo_pop  output  1  one-cycle pulse: head flit delivered to every requested output.
REQ-012 drop_pulse  output  1  one-cycle pulse: head flit discarded as unroutable.
REQ-013 stall_cnt  output  16  saturating count of REQ cycles without pop.

Function
REQ-014 Buffer: circular FIFO, DEPTH entries, wrapping read and write pointers, occupancy count 0..DEPTH.
REQ-015 in_ready SHALL equal (count<DEPTH); there is no full-bypass, so a push is refused when full even if a pop occurs in the same cycle.
REQ-016 A push (in_valid&&in_ready) and a pop or drop in the same cycle SHALL leave count unchanged and both SHALL take effect.
REQ-017 FSM states: IDLE (nothing decoded), DECODE (head mask computed), REQ (requesting).
REQ-018 IDLE->DECODE when count>0; DECODE always exits after exactly one cycle.
REQ-019 DECODE computes the mask: if enable_mcast is 1, mask=head[4:0]; otherwise mask=onehot(head[2:0]), or 0 when the index is >4. Bit PORT_ID of the mask is then forced to 0 (no U-turn). enable_mcast is sampled only in DECODE.
REQ-020 DECODE->REQ with req=mask when mask!=0; when mask==0, assert drop_pulse, pop the entry, and go to IDLE.
REQ-021 In REQ, req SHALL be held constant; a pop occurs only when (grant&req)==req, making delivery all-or-nothing. Partial grants SHALL NOT pop and SHALL NOT alter req.
REQ-022 On pop: fifo_pop=1 that cycle; req=0 next cycle; state->IDLE; stall_cnt cleared to 0.
REQ-023 Each REQ cycle without pop SHALL increment stall_cnt, saturating at 16'hFFFF.
REQ-024 Grant bits outside req SHALL be ignored.
REQ-025 Latency: a flit pushed at cycle N into an empty buffer is in DECODE at N+1, asserts req at N+2, and can earliest pop at N+2.
REQ-026 Back-to-back throughput is one flit per 3 cycles (IDLE, DECODE, REQ).
REQ-027 fifo_pop and drop_pulse SHALL never both be 1 in the same cycle.
REQ-028 head_flit SHALL equal the entry at the read pointer, and SHALL be 0 when count==0.

Reset
REQ-029 While rst_n=0, asynchronously: pointers=0, count=0, state=IDLE, req=0, fifo_pop=0, drop_pulse=0, stall_cnt=0, in_ready=1 after reset; head_flit=0.
REQ-030 Reset mid-REQ SHALL discard all buffered flits with no fifo_pop or drop_pulse; after release, operation resumes from IDLE within one cycle.

Verification
REQ-031 PORT_ID=0, enable_mcast=1, push flit[4:0]=5'b10110 at cycle 0, grant=5'b10110 from cycle 2 -> req=5'b10110 at cycle 2, fifo_pop=1 at cycle 2, req=0 at cycle 3.
REQ-032 Partial grant: req=5'b00110, grant=5'b00010 for 3 cycles, then 5'b00110 -> no pop for 3 cycles, stall_cnt=3, pop on the 4th cycle, then stall_cnt=0.
REQ-033 PORT_ID=2: multicast mask 5'b00100 -> drop_pulse=1 in DECODE and no req; unicast index 3'd6 with enable_mcast=0 -> drop_pulse=1.
REQ-034 Push 5 flits with no grant and DEPTH=4 -> in_ready=0 after 4 accepted; grant -> entries pop in order; a push in a pop cycle is accepted and count stays at 4 after refill.
REQ-035 Assert rst_n=0 while in REQ with 3 flits buffered -> req=0 immediately, count=0, no pulses; a subsequent push behaves as in REQ-031.

Source files
------------

// File: rtl/mcast_ingress_port.sv
// Router input port: buffers incoming flits, decodes a uni/multicast destination
// mask from the head flit and holds the request until every target grants at once.
module mcast_ingress_port #(
  parameter int FLIT_W  = 64,
  parameter int DEPTH   = 4,
  parameter int PORT_ID = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_mcast,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic [4:0]        req,
  output logic [FLIT_W-1:0] head_flit,
  input  logic [4:0]        grant,
  output logic              fifo_pop,
  output logic              drop_pulse,
  output logic [15:0]       stall_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(DEPTH);
  localparam logic [4:0]     UTURN = 5'(1) << PORT_ID;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_REQ    = 2'd2;

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [1:0]        state;
  logic [4:0]        mask;
  logic              push, pop_any;

  assign in_ready   = count < FULL;
  assign push       = in_valid && in_ready;
  assign head_flit  = (count != '0) ? mem[rd_ptr] : '0;
  // req is nonzero whenever in REQ, so a full match means every target granted
  assign fifo_pop   = (state == S_REQ) && ((grant & req) == req);
  assign drop_pulse = (state == S_DECODE) && (mask == 5'd0);
  assign pop_any    = fifo_pop || drop_pulse;

  always_comb begin
    mask = 5'd0;
    if (enable_mcast)
      mask = head_flit[4:0];
    else if (head_flit[2:0] <= 3'd4)
      mask = 5'(1) << head_flit[2:0];
    mask = mask & ~UTURN;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_flit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      state     <= S_IDLE;
      req       <= 5'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_any) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop_any)      count <= count + (PTR_W+1)'(1);
      else if (!push && pop_any) count <= count - (PTR_W+1)'(1);

      case (state)
        // a flit landing this edge is readable next cycle, so DECODE can follow directly
        S_IDLE: if (count != '0 || push) state <= S_DECODE;
        S_DECODE: begin
          if (mask != 5'd0) begin
            req   <= mask;
            state <= S_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (fifo_pop) begin
            req       <= 5'd0;
            stall_cnt <= 16'd0;
            state     <= S_IDLE;
          end else if (stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mcast_ingress_port.sv
// Scoreboarded bench: stimulus queues expected pop/drop events, a negedge monitor
// compares them against what each port instance actually delivers or discards.
module tb_mcast_ingress_port;
  localparam int W = 64;

  logic         clk = 1'b0, rst_n = 1'b0, en = 1'b1;
  logic         iv1 = 1'b0, iv2 = 1'b0;
  logic [W-1:0] if1 = '0, if2 = '0;
  logic [4:0]   g1 = '0, g2 = '0;
  logic         rdy1, rdy2, pop1, pop2, drp1, drp2;
  logic [4:0]   req1, req2;
  logic [W-1:0] hd1, hd2;
  logic [15:0]  st1, st2;

  always #5 clk = ~clk;

  mcast_ingress_port #(.FLIT_W(W), .DEPTH(4), .PORT_ID(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .enable_mcast(en), .in_valid(iv1), .in_ready(rdy1),
    .in_flit(if1), .req(req1), .head_flit(hd1), .grant(g1), .fifo_pop(pop1),
    .drop_pulse(drp1), .stall_cnt(st1));

  mcast_ingress_port #(.FLIT_W(W), .DEPTH(4), .PORT_ID(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable_mcast(en), .in_valid(iv2), .in_ready(rdy2),
    .in_flit(if2), .req(req2), .head_flit(hd2), .grant(g2), .fifo_pop(pop2),
    .drop_pulse(drp2), .stall_cnt(st2));

  typedef struct packed {logic drop; logic [4:0] req; logic [W-1:0] flit;} ev_t;
  ev_t q1[$], q2[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [W+5:0] act, input logic [W+5:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every pop or drop must match the oldest expected event
  always @(negedge clk) begin
    if (rst_n) begin
      if (pop1 || drp1) begin
        if (q1.size() == 0) begin
          tests++; fails++;
          $display("FAIL p0 unexpected event: drop=%0b req=%0h flit=%0h", drp1, req1, hd1);
        end else begin
          chk("p0 event", {drp1, req1, hd1}, q1.pop_front());
        end
        chk("p0 pop/drop exclusive", 66'(pop1 & drp1), 66'd0);
      end
      if (pop2 || drp2) begin
        if (q2.size() == 0) begin
          tests++; fails++;
          $display("FAIL p2 unexpected event: drop=%0b req=%0h flit=%0h", drp2, req2, hd2);
        end else begin
          chk("p2 event", {drp2, req2, hd2}, q2.pop_front());
        end
      end
    end
  end

  // Single push on port 0 or 2; caller presets grant so a routable flit pops at cycle 2
  task automatic send(input int p, input logic [W-1:0] f, input logic drop, input logic [4:0] m);
    if (p == 0) begin q1.push_back({drop, m, f}); iv1 = 1'b1; if1 = f; end
    else        begin q2.push_back({drop, m, f}); iv2 = 1'b1; if2 = f; end
    step();
    iv1 = 1'b0; iv2 = 1'b0;
    at_neg();
    chk($sformatf("p%0d drop in decode %0h", p, f[4:0]), 66'(p == 0 ? drp1 : drp2), 66'(drop));
    repeat (3) step();
  endtask

  task automatic basic(input string tag);
    en = 1'b1; g1 = 5'd0;
    if1 = 64'hC0DE_0000_0000_0016; iv1 = 1'b1;
    q1.push_back({1'b0, 5'b10110, if1});
    at_neg(); chk({tag, " in_ready"}, 66'(rdy1), 66'd1);
    step(); iv1 = 1'b0;
    at_neg(); chk({tag, " decode req"}, 66'(req1), 66'd0);
    step(); g1 = 5'b10110;
    at_neg(); chk({tag, " req c2"}, 66'(req1), 66'b10110);
    chk({tag, " pop c2"}, 66'(pop1), 66'd1);
    step(); g1 = 5'd0;
    at_neg(); chk({tag, " req c3"}, 66'(req1), 66'd0);
    chk({tag, " pop c3"}, 66'(pop1), 66'd0);
    step();
  endtask

  initial begin
    #2;
    chk("reset in_ready", 66'(rdy1), 66'd1);
    chk("reset req", 66'(req1), 66'd0);
    chk("reset head", 66'(hd1), 66'd0);
    chk("reset pulses", 66'({pop1, drp1}), 66'd0);
    chk("reset stall", 66'(st1), 66'd0);
    at_neg(); rst_n = 1'b1;
    step();

    basic("basic");

    // Partial grant: req held, stall counts, pop only on full grant
    g1 = 5'b00010; if1 = 64'h1111_0000_0000_0006; iv1 = 1'b1;
    q1.push_back({1'b0, 5'b00110, if1});
    step(); iv1 = 1'b0;
    step();
    at_neg(); chk("partial req c2", 66'(req1), 66'b00110); chk("partial nopop c2", 66'(pop1), 66'd0);
    step();
    at_neg(); chk("partial stall 1", 66'(st1), 66'd1); chk("partial req c3", 66'(req1), 66'b00110);
    step();
    at_neg(); chk("partial stall 2", 66'(st1), 66'd2);
    step(); g1 = 5'b00110;
    at_neg(); chk("partial stall 3", 66'(st1), 66'd3); chk("partial pop", 66'(pop1), 66'd1);
    step(); g1 = 5'd0;
    at_neg(); chk("partial stall clr", 66'(st1), 66'd0); chk("partial req clr", 66'(req1), 66'd0);
    step();

    // Unicast decode on port 0, upper mask bits ignored; index 0 is a U-turn
    en = 1'b0; g1 = 5'b11111;
    send(0, 64'h2222_0000_0000_001C, 1'b0, 5'b10000);
    send(0, 64'h2223_0000_0000_0001, 1'b0, 5'b00010);
    send(0, 64'h2224_0000_0000_0000, 1'b1, 5'b00000);
    g1 = 5'd0;

    // Port 2: self-only multicast and out-of-range unicast drop
    en = 1'b1; g2 = 5'b11111;
    send(2, 64'h3333_0000_0000_0004, 1'b1, 5'b00000);
    send(2, 64'h3334_0000_0000_0007, 1'b0, 5'b00011);
    en = 1'b0;
    send(2, 64'h3335_0000_0000_0006, 1'b1, 5'b00000);
    send(2, 64'h3336_0000_0000_0002, 1'b1, 5'b00000);
    send(2, 64'h3337_0000_0000_0003, 1'b0, 5'b01000);
    en = 1'b1; g2 = 5'd0;

    // Fill to DEPTH, refused fifth push even in the pop cycle, in-order drain
    for (int i = 0; i < 4; i++) begin
      iv1 = 1'b1; if1 = 64'hA000 + 64'(1 << (i + 1));
      q1.push_back({1'b0, 5'(1 << (i + 1)), if1});
      step();
    end
    if1 = 64'hA0E2; q1.push_back({1'b0, 5'b00010, if1});
    at_neg(); chk("full in_ready", 66'(rdy1), 66'd0);
    step(); g1 = 5'b11111;
    at_neg(); chk("full pop", 66'(pop1), 66'd1); chk("full pop no push", 66'(rdy1), 66'd0);
    step();
    at_neg(); chk("refill in_ready", 66'(rdy1), 66'd1);
    step(); iv1 = 1'b0;
    at_neg(); chk("refill full again", 66'(rdy1), 66'd0);
    for (int i = 0; i < 60 && q1.size() > 0; i++) step();
    at_neg(); chk("drain head zero", 66'(hd1), 66'd0);
    step();

    // Push in the same cycle as a pop
    g1 = 5'b01000; if1 = 64'hB008; iv1 = 1'b1;
    q1.push_back({1'b0, 5'b01000, if1});
    step(); iv1 = 1'b0;
    step(); iv1 = 1'b1; if1 = 64'hB108;
    q1.push_back({1'b0, 5'b01000, if1});
    at_neg(); chk("pushpop pop", 66'(pop1), 66'd1); chk("pushpop in_ready", 66'(rdy1), 66'd1);
    step(); iv1 = 1'b0;
    at_neg(); chk("pushpop head", 66'(hd1), 66'hB108);
    repeat (4) step();
    g1 = 5'd0;

    // Stall counter saturation
    if1 = 64'hC002; iv1 = 1'b1;
    step(); iv1 = 1'b0;
    repeat (65540) step();
    at_neg(); chk("stall saturate", 66'(st1), 66'hFFFF);
    step(); g1 = 5'b00010;
    q1.push_back({1'b0, 5'b00010, 64'hC002});
    at_neg(); chk("sat pop", 66'(pop1), 66'd1);
    step(); g1 = 5'd0;
    at_neg(); chk("sat stall clr", 66'(st1), 66'd0);
    step();

    // Reset while requesting with three flits buffered
    for (int i = 0; i < 3; i++) begin
      iv1 = 1'b1; if1 = 64'hD002 + 64'(i << 8); step();
    end
    iv1 = 1'b0;
    at_neg(); chk("pre-reset req", 66'(req1), 66'b00010);
    step(); #2 rst_n = 1'b0; #1;
    chk("mid-reset req", 66'(req1), 66'd0);
    chk("mid-reset in_ready", 66'(rdy1), 66'd1);
    chk("mid-reset head", 66'(hd1), 66'd0);
    chk("mid-reset pulses", 66'({pop1, drp1}), 66'd0);
    repeat (2) step();
    at_neg(); rst_n = 1'b1;
    step();
    basic("post-reset");

    for (int i = 0; i < 50 && (q1.size() + q2.size()) > 0; i++) step();
    chk("scoreboard empty", 66'(q1.size() + q2.size()), 66'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
